// File: rtl/mx_cell_pkg.sv
// mx_cell_pkg: shared sizes and the per-lane state record for the bit-serial
// MAC cell (mx_cell / mx_lane).
//   LANES    - number of time-interleaved MAC lanes
//   DATA_W   - serial data operand width (bits consumed per operation)
//   WEIGHT_W - weight magnitude width (also width of the partial register)
//   ACC_W    - accumulator / result stream length in bits
package mx_cell_pkg;
    localparam int LANES    = 4;
    localparam int DATA_W   = 8;
    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = 32;

    // Data-bit counter saturates at DATA_W; after that the multiplier only
    // shifts out the remaining partial-product bits.
    localparam int              CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    typedef struct packed {
        logic [WEIGHT_W-1:0] p;      // serial-parallel multiplier partial
        logic                carry;  // serial adder carry
        logic [CNT_W-1:0]    cnt;    // data bits consumed, saturating
    } lane_state_t;
endpackage

// File: rtl/mx_cell_if.sv
// mx_cell_if: dataflow, weight-load and per-lane serial MAC signals of one
// systolic cell.
//   master - environment / upstream side (drives the *_i inputs, reads outputs)
//   slave  - the cell itself
interface mx_cell_if;
    import mx_cell_pkg::*;

    logic [1:0]       dataflow_in;
    logic             dataflow_select;
    logic             update_w_i;
    logic             control1;
    logic [LANES-1:0] clr_and_plus_one_i;
    logic [LANES-1:0] mac_en_i;
    logic [LANES-1:0] accumulation_in;
    logic [LANES-1:0] result;
    logic [1:0]       dataflow_out;
    logic [LANES-1:0] clr_and_plus_one_o;
    logic [LANES-1:0] mac_en_o;

    modport master (
        output dataflow_in, dataflow_select, update_w_i, control1,
               clr_and_plus_one_i, mac_en_i, accumulation_in,
        input  result, dataflow_out, clr_and_plus_one_o, mac_en_o
    );

    modport slave (
        input  dataflow_in, dataflow_select, update_w_i, control1,
               clr_and_plus_one_i, mac_en_i, accumulation_in,
        output result, dataflow_out, clr_and_plus_one_o, mac_en_o
    );
endinterface

// File: rtl/mx_lane.sv
// mx_lane: one bit-serial MAC lane, result = data * (+/-w) + acc, LSB first.
// Ports:
//   clk, reset - clock, synchronous active-low reset
//   w, sign    - shared weight magnitude and sign (1 = positive/zero)
//   din        - shared serial data bit
//   update_w   - weight load in progress; forces the data bit to zero
//   clr        - start-of-operation strobe (bit 0)
//   en         - bit valid; lane state is frozen while low
//   acc_in     - serial accumulator bit
//   result     - registered serial result bit
module mx_lane
    import mx_cell_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [WEIGHT_W-1:0] w,
    input  logic                sign,
    input  logic                din,
    input  logic                update_w,
    input  logic                clr,
    input  logic                en,
    input  logic                acc_in,
    output logic                result
);
    lane_state_t         st_q, st_d, base;
    logic                res_q, res_d;
    logic                d, pb, q;
    logic [WEIGHT_W:0]   s;

    always_comb begin
        base = st_q;
        // A new operation starts from an empty partial product. For a
        // negative weight the product bits are inverted and the +1 of the
        // two's-complement negation enters through the initial carry.
        if (clr) begin
            base.p     = '0;
            base.carry = ~sign;
            base.cnt   = '0;
        end
        d  = din & ~update_w & (base.cnt < CNT_MAX);
        s  = {1'b0, base.p} + (d ? {1'b0, w} : '0);
        pb = s[0];
        q  = sign ? pb : ~pb;

        st_d  = st_q;
        res_d = res_q;
        if (en) begin
            {st_d.carry, res_d} = 2'(acc_in) + 2'(q) + 2'(base.carry);
            st_d.p   = s[WEIGHT_W:1];
            st_d.cnt = (base.cnt == CNT_MAX) ? CNT_MAX : base.cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= '0;
            res_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;
endmodule

// File: rtl/mx_cell.sv
// mx_cell: systolic bit-serial MAC cell with LANES time-interleaved lanes
// sharing one sign-magnitude weight.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-low reset
//   bus   - mx_cell_if.slave: dataflow in/out, weight load (update_w_i,
//           control1), per-lane strobe/valid/acc inputs, per-lane result and
//           forwarded strobe/valid.
// Build option: MX_CELL_BYPASS_EN - when defined, dataflow_select=1 routes
// dataflow_in straight to dataflow_out; otherwise dataflow_out is always the
// registered copy and dataflow_select is ignored.
module mx_cell
    import mx_cell_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mx_cell_if.slave    bus
);
    logic [WEIGHT_W-1:0] w_q, w_d;
    logic                sign_q, sign_d;
    logic [1:0]          df_q, df_d;
    logic [LANES-1:0]    clr_q, clr_d, en_q, en_d;
    logic [LANES-1:0]    res;

    always_comb begin
        w_d    = w_q;
        sign_d = sign_q;
        // Weight arrives two bits per cycle, lowest pair first.
        if (bus.update_w_i) begin
            w_d    = {bus.dataflow_in, w_q[WEIGHT_W-1:2]};
            sign_d = bus.control1;
        end
        df_d  = bus.dataflow_in;
        clr_d = bus.clr_and_plus_one_i;
        en_d  = bus.mac_en_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q    <= '0;
            sign_q <= 1'b1;
            df_q   <= '0;
            clr_q  <= '0;
            en_q   <= '0;
        end else begin
            w_q    <= w_d;
            sign_q <= sign_d;
            df_q   <= df_d;
            clr_q  <= clr_d;
            en_q   <= en_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mx_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .w        (w_q),
            .sign     (sign_q),
            .din      (bus.dataflow_in[0]),
            .update_w (bus.update_w_i),
            .clr      (bus.clr_and_plus_one_i[k]),
            .en       (bus.mac_en_i[k]),
            .acc_in   (bus.accumulation_in[k]),
            .result   (res[k])
        );
    end

    assign bus.result             = res;
    assign bus.clr_and_plus_one_o = clr_q;
    assign bus.mac_en_o           = en_q;

`ifdef MX_CELL_BYPASS_EN
    assign bus.dataflow_out = bus.dataflow_select ? bus.dataflow_in : df_q;
`else
    logic unused_sel;
    assign unused_sel       = bus.dataflow_select;
    assign bus.dataflow_out = df_q;
`endif
endmodule

// File: tb/tb_mx_cell.sv
module tb_mx_cell;
    import mx_cell_pkg::*;

    localparam int MAXC = 320;

    typedef struct {
        logic [7:0] mag;
        logic       neg;
        logic [7:0] data;
        int         acc;
        int         ex;
    } vec_t;

    typedef struct {
        int          lane;
        logic [31:0] ex;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mx_cell_if bus();
    mx_cell dut (.clk(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Per-cycle stimulus plan for one batch of operations.
    logic [LANES-1:0] pl_en  [MAXC];
    logic [LANES-1:0] pl_clr [MAXC];
    logic [LANES-1:0] pl_acc [MAXC];
    logic             pl_din [MAXC];
    logic             pl_stb [MAXC];
    exp_t             pl_exp [MAXC];
    int               pl_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, $signed(act), act, $signed(req), req);
        end
    endtask

    // Monitor: assemble each lane's 32 result bits under mac_en_o, framed by
    // the forwarded strobe, and compare against the scoreboard.
    int          mon_cnt  [LANES];
    logic [31:0] mon_word [LANES];
    exp_t        mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (bus.mac_en_o[k]) begin
                if (bus.clr_and_plus_one_o[k]) begin
                    mon_cnt[k]  = 0;
                    mon_word[k] = '0;
                end
                if (mon_cnt[k] < ACC_W) mon_word[k][5'(mon_cnt[k])] = bus.result[k];
                mon_cnt[k]++;
                if (mon_cnt[k] == ACC_W) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result lane%0d: got %0d, none expected",
                                 k, $signed(mon_word[k]));
                    end else begin
                        mon_e = exp_q.pop_front();
                        check($sformatf("result_lane%0d", k), mon_word[k], mon_e.ex);
                        check("lane_order", 32'(k), 32'(mon_e.lane));
                    end
                end
            end
        end
    end

    task automatic set_idle();
        bus.update_w_i         = 1'b0;
        bus.dataflow_in        = 2'b00;
        bus.mac_en_i           = '0;
        bus.clr_and_plus_one_i = '0;
        bus.accumulation_in    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_idle();
        end
    endtask

    task automatic plan_clear();
        for (int t = 0; t < MAXC; t++) begin
            pl_en[t]  = '0;
            pl_clr[t] = '0;
            pl_acc[t] = '0;
            pl_din[t] = 1'b0;
            pl_stb[t] = 1'b0;
        end
        pl_len = 0;
    endtask

    task automatic plan_op(input int lane, input int start, input logic [7:0] data,
                           input int acc, input int ex);
        logic [31:0] a;
        a = acc;
        for (int i = 0; i < ACC_W; i++) begin
            pl_en[start+i][lane]  = 1'b1;
            pl_acc[start+i][lane] = a[5'(i)];
            if (i < DATA_W) pl_din[start+i] = data[3'(i)];
        end
        pl_clr[start][lane] = 1'b1;
        pl_stb[start]       = 1'b1;
        pl_exp[start]       = '{lane, 32'(ex)};
        if (start + ACC_W > pl_len) pl_len = start + ACC_W;
    endtask

    task automatic drive_cycle(input int t);
        @(posedge clk); #1;
        bus.update_w_i         = 1'b0;
        bus.dataflow_in        = {1'b0, pl_din[t]};
        bus.mac_en_i           = pl_en[t];
        bus.clr_and_plus_one_i = pl_clr[t];
        bus.accumulation_in    = pl_acc[t];
        if (pl_stb[t]) exp_q.push_back(pl_exp[t]);
    endtask

    // Play the whole plan, let the pipeline drain, and make sure every
    // expected result came out (bounded: a missing result is a failure).
    task automatic play(input string name);
        for (int t = 0; t < pl_len; t++) drive_cycle(t);
        idle(3);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_w(input logic [7:0] mag, input logic neg);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            set_idle();
            bus.update_w_i  = 1'b1;
            bus.control1    = ~neg;
            bus.dataflow_in = {mag[3'(2*i+1)], mag[3'(2*i)]};
        end
        idle(1);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_result"},  32'(bus.result),             32'd0);
        check({name, "_dfout"},   32'(bus.dataflow_out),       32'd0);
        check({name, "_clr_o"},   32'(bus.clr_and_plus_one_o), 32'd0);
        check({name, "_mac_en_o"},32'(bus.mac_en_o),           32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        int   c;
        int   wv;
        logic [7:0] dv;
        int   av;

        vecs[0]  = '{8'd3,   1'b0, 8'd5,   -2,          13};
        vecs[1]  = '{8'd10,  1'b1, 8'd9,   -10,         -100};
        vecs[2]  = '{8'd10,  1'b1, 8'd12,  -7,          -127};
        vecs[3]  = '{8'd0,   1'b0, 8'd0,   7,           7};
        vecs[4]  = '{8'd1,   1'b1, 8'd0,   7,           7};
        vecs[5]  = '{8'd0,   1'b1, 8'd0,   7,           7};
        vecs[6]  = '{8'd0,   1'b0, 8'd200, -5,          -5};
        vecs[7]  = '{8'd255, 1'b0, 8'd255, 0,           65025};
        vecs[8]  = '{8'd255, 1'b1, 8'd255, 0,           -65025};
        vecs[9]  = '{8'd1,   1'b1, 8'd1,   0,           -1};
        vecs[10] = '{8'd2,   1'b0, 8'd4,   1,           9};
        vecs[11] = '{8'd1,   1'b0, 8'd1,   32'h7fffffff, 32'h80000000};

        for (int k = 0; k < LANES; k++) begin
            mon_cnt[k]  = 0;
            mon_word[k] = '0;
        end

        // Reset with busy-looking inputs: all outputs must stay cleared.
        set_idle();
        bus.control1        = 1'b1;
        bus.dataflow_select = 1'b0;
        bus.dataflow_in     = 2'b11;
        bus.mac_en_i        = '1;
        bus.clr_and_plus_one_i = '1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle();
        idle(2);

        // Reset weight is zero: any data leaves the accumulator unchanged.
        plan_clear();
        plan_op(1, 0, 8'd5, 7, 7);
        play("reset_weight");

        // Single-lane vector table, lane rotates per vector.
        foreach (vecs[i]) begin
            load_w(vecs[i].mag, vecs[i].neg);
            plan_clear();
            plan_op(i % LANES, 0, vecs[i].data, vecs[i].acc, vecs[i].ex);
            play($sformatf("vec%0d", i));
        end

        // W = -10, all four lanes staggered by 8 cycles.
        load_w(8'd10, 1'b1);
        plan_clear();
        plan_op(0, 0,  8'd9,  -10, -100);
        plan_op(1, 8,  8'd10, -9,  -109);
        plan_op(2, 16, 8'd11, -8,  -118);
        plan_op(3, 24, 8'd12, -7,  -127);
        play("stagger");

        // Sweep weights, two back-to-back operations per lane.
        c = 0;
        for (int w = -10; w <= 9; w++) begin
            load_w(8'(w < 0 ? -w : w), (w < 0) ? 1'b1 : 1'b0);
            plan_clear();
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < LANES; k++) begin
                    dv = 8'(c % 10);
                    av = (c * 7) % 20 - 10;
                    wv = w;
                    plan_op(k, 8*k + 32*j, dv, av, int'(dv) * wv + av);
                    c++;
                end
            end
            play($sformatf("sweep_w%0d", w));
        end

        // Reset in the middle of a lane-0 operation (at bit 15).
        load_w(8'd3, 1'b0);
        plan_clear();
        plan_op(0, 0, 8'd5, -2, 13);
        for (int t = 0; t < 15; t++) drive_cycle(t);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dataflow_in = 2'b11;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midop_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle();
        idle(2);
        load_w(8'd2, 1'b0);
        plan_clear();
        plan_op(0, 0, 8'd4, 1, 9);
        play("after_reset");

        // Dataflow forwarding latency.
        idle(2);
        @(posedge clk); #1;
        bus.dataflow_in = 2'b10;
        @(negedge clk);
        check("dfout_before_edge", 32'(bus.dataflow_out), 32'd0);
        @(negedge clk);
        check("dfout_registered", 32'(bus.dataflow_out), 32'd2);
`ifdef MX_CELL_BYPASS_EN
        bus.dataflow_select = 1'b1;
        bus.dataflow_in     = 2'b01;
        #1;
        check("dfout_bypass", 32'(bus.dataflow_out), 32'd1);
        bus.dataflow_select = 1'b0;
`endif
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
